// File: rtl/bus_decoder.sv
// Registered bus decoder and transaction sequencer.
// Maps the host address onto N peripherals with an ack handshake, a timeout watchdog and an error response.
module bus_decoder #(
  parameter int NUM_DEVICES    = 4,
  parameter int DEV_ADDR_WIDTH = 14,
  parameter int BUS_ADDR_WIDTH = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT        = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DEV_ADDR_WIDTH+BUS_ADDR_WIDTH-1:0] addr,
  input  logic                                   wr_en,
  input  logic                                   rd_en,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err,
  output logic [NUM_DEVICES-1:0]                 cs,
  output logic [DEV_ADDR_WIDTH-1:0]              dev_addr,
  output logic [DATA_WIDTH-1:0]                  dev_wr_data,
  output logic                                   dev_we,
  output logic                                   dev_re,
  input  logic [NUM_DEVICES*DATA_WIDTH-1:0]      dev_rd_data,
  input  logic [NUM_DEVICES-1:0]                 dev_ack
);

  localparam int AW        = DEV_ADDR_WIDTH + BUS_ADDR_WIDTH;
  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                     state_reg, state_next;
  logic [NUM_DEVICES-1:0]     cs_reg, cs_next;
  logic [DEV_ADDR_WIDTH-1:0]  dev_addr_reg, dev_addr_next;
  logic [DATA_WIDTH-1:0]      dev_wr_data_reg, dev_wr_data_next;
  logic                       dev_we_reg, dev_we_next;
  logic                       dev_re_reg, dev_re_next;
  logic [CNT_WIDTH-1:0]       cnt_reg, cnt_next;
  logic                       done_reg, done_next;
  logic                       err_reg, err_next;
  logic [DATA_WIDTH-1:0]      rd_data_reg, rd_data_next;

  logic [BUS_ADDR_WIDTH-1:0]  req_idx;
  logic                       req_mapped;
  logic [NUM_DEVICES-1:0]     req_onehot;
  logic                       ack_hit;
  logic [DATA_WIDTH-1:0]      rd_slice [NUM_DEVICES];
  logic [DATA_WIDTH-1:0]      sel_rd_data;

  assign req_idx    = addr[AW-1:DEV_ADDR_WIDTH];
  assign req_mapped = (int'(req_idx) < NUM_DEVICES);
  // cs_reg is one-hot in ACCESS, so masking with it both filters foreign acks and muxes read data.
  assign ack_hit    = |(dev_ack & cs_reg);

  generate
    for (genvar gi = 0; gi < NUM_DEVICES; gi++) begin : g_dev
      assign req_onehot[gi] = (int'(req_idx) == gi);
      assign rd_slice[gi]   = cs_reg[gi] ? dev_rd_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    sel_rd_data = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      sel_rd_data = sel_rd_data | rd_slice[i];
    end
  end

  always_comb begin
    state_next       = state_reg;
    cs_next          = cs_reg;
    dev_addr_next    = dev_addr_reg;
    dev_wr_data_next = dev_wr_data_reg;
    dev_we_next      = dev_we_reg;
    dev_re_next      = dev_re_reg;
    cnt_next         = cnt_reg;
    done_next        = 1'b0;
    err_next         = 1'b0;
    rd_data_next     = rd_data_reg;
    case (state_reg)
      IDLE: begin
        if (wr_en || rd_en) begin
          if (req_mapped) begin
            state_next       = ACCESS;
            cs_next          = req_onehot;
            dev_addr_next    = addr[DEV_ADDR_WIDTH-1:0];
            dev_wr_data_next = wr_data;
            dev_we_next      = wr_en;
            dev_re_next      = ~wr_en;
            cnt_next         = '0;
          end else begin
            state_next = RESP;
            done_next  = 1'b1;
            err_next   = 1'b1;
            if (!wr_en) rd_data_next = '1;
          end
        end
      end
      ACCESS: begin
        if (ack_hit || cnt_reg == CNT_LAST) begin
          state_next       = RESP;
          done_next        = 1'b1;
          err_next         = ~ack_hit;
          if (dev_re_reg) rd_data_next = ack_hit ? sel_rd_data : '1;
          cs_next          = '0;
          dev_addr_next    = '0;
          dev_wr_data_next = '0;
          dev_we_next      = 1'b0;
          dev_re_next      = 1'b0;
          cnt_next         = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cs_reg          <= '0;
      dev_addr_reg    <= '0;
      dev_wr_data_reg <= '0;
      dev_we_reg      <= 1'b0;
      dev_re_reg      <= 1'b0;
      cnt_reg         <= '0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      rd_data_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      cs_reg          <= cs_next;
      dev_addr_reg    <= dev_addr_next;
      dev_wr_data_reg <= dev_wr_data_next;
      dev_we_reg      <= dev_we_next;
      dev_re_reg      <= dev_re_next;
      cnt_reg         <= cnt_next;
      done_reg        <= done_next;
      err_reg         <= err_next;
      rd_data_reg     <= rd_data_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign err         = err_reg;
  assign cs          = cs_reg;
  assign dev_addr    = dev_addr_reg;
  assign dev_wr_data = dev_wr_data_reg;
  assign dev_we      = dev_we_reg;
  assign dev_re      = dev_re_reg;
  assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: a 4-device instance for most scenarios and
// a 3-device instance for the unmapped-index case, checked against a transaction-level model.
module tb_bus_decoder;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr, wr_data, rd_data, dev_wr_data;
  logic        wr_en, rd_en, busy, done, err, dev_we, dev_re;
  logic [3:0]  cs, dev_ack;
  logic [13:0] dev_addr;
  logic [63:0] dev_rd_data;

  logic [15:0] addr3, wr_data3, rd_data3, dev_wr_data3;
  logic        wr_en3, rd_en3, busy3, done3, err3, dev_we3, dev_re3;
  logic [2:0]  cs3, dev_ack3;
  logic [13:0] dev_addr3;
  logic [47:0] dev_rd_data3;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_rd = '0;   // model of the host-visible read-data register (4-device instance)

  always #5 clk = ~clk;

  bus_decoder #(.NUM_DEVICES(4), .DEV_ADDR_WIDTH(14), .BUS_ADDR_WIDTH(2), .DATA_WIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err), .cs(cs), .dev_addr(dev_addr),
    .dev_wr_data(dev_wr_data), .dev_we(dev_we), .dev_re(dev_re), .dev_rd_data(dev_rd_data), .dev_ack(dev_ack));

  bus_decoder #(.NUM_DEVICES(3), .DEV_ADDR_WIDTH(14), .BUS_ADDR_WIDTH(2), .DATA_WIDTH(16), .TIMEOUT(TIMEOUT)) dut3 (
    .clk(clk), .reset(reset), .addr(addr3), .wr_en(wr_en3), .rd_en(rd_en3), .wr_data(wr_data3),
    .rd_data(rd_data3), .busy(busy3), .done(done3), .err(err3), .cs(cs3), .dev_addr(dev_addr3),
    .dev_wr_data(dev_wr_data3), .dev_we(dev_we3), .dev_re(dev_re3), .dev_rd_data(dev_rd_data3), .dev_ack(dev_ack3));

  // One transaction on the 4-device instance. Called and returns just after a falling edge.
  // ack_delay = k asserts the target's ack for edge T+k (0 or > TIMEOUT: never within the window).
  // spur forces extra acks on other devices; hold keeps random strobes/addresses up while busy.
  task automatic run_txn(input logic [15:0] a, input logic w, input logic r, input logic [15:0] wd,
                         input int ack_delay, input logic [3:0] spur, input logic hold);
    int          idx, done_c;
    logic        ok_ack, is_rd;
    logic [3:0]  exp_cs;
    logic [15:0] cap;
    logic [24:0] exp_ctl, obs_ctl;
    logic [29:0] exp_bus, obs_bus;
    idx    = int'(a[15:14]);
    is_rd  = !w && r;
    ok_ack = (ack_delay >= 1 && ack_delay <= TIMEOUT);
    done_c = ok_ack ? ack_delay + 1 : TIMEOUT + 1;
    exp_cs = 4'b0001 << idx;
    cap    = '1;
    addr = a; wr_en = w; rd_en = r; wr_data = wd; dev_ack = '0;
    dev_rd_data = {$urandom, $urandom};
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      if (c < done_c) begin
        exp_ctl = {1'b1, 1'b0, 1'b0, exp_cs, w, is_rd, exp_rd};
        exp_bus = {a[13:0], wd};
      end else if (c == done_c) begin
        if (is_rd) exp_rd = ok_ack ? cap : 16'hFFFF;
        exp_ctl = {1'b1, 1'b1, ~ok_ack, 4'b0, 1'b0, 1'b0, exp_rd};
        exp_bus = '0;
      end else begin
        exp_ctl = {3'b000, 4'b0, 1'b0, 1'b0, exp_rd};
        exp_bus = '0;
      end
      obs_ctl = {busy, done, err, cs, dev_we, dev_re, rd_data};
      obs_bus = {dev_addr, dev_wr_data};
      n_cmp++;
      if (obs_ctl !== exp_ctl) begin
        n_err++;
        $display("FAIL txn a=%h c=%0d ctl{busy,done,err,cs,we,re,rd_data}: got %h want %h", a, c, obs_ctl, exp_ctl);
      end
      if (c != done_c) begin
        n_cmp++;
        if (obs_bus !== exp_bus) begin
          n_err++;
          $display("FAIL txn a=%h c=%0d bus{dev_addr,dev_wr_data}: got %h want %h", a, c, obs_bus, exp_bus);
        end
      end
      if (c <= done_c) begin
        if (hold) begin
          addr = 16'($urandom); wr_en = 1'($urandom); rd_en = 1'b1;
        end else begin
          wr_en = 1'b0; rd_en = 1'b0;
        end
        dev_rd_data = {$urandom, $urandom};
        dev_ack = (4'($urandom) | spur) & ~exp_cs;
        if (c == ack_delay) begin
          dev_ack = dev_ack | exp_cs;
          cap = dev_rd_data[idx*16 +: 16];
        end
        @(posedge clk); @(negedge clk);
      end else begin
        wr_en = 1'b0; rd_en = 1'b0; dev_ack = '0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = 16'h4000; wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h5A5A;
    dev_ack = '0; dev_rd_data = '0;
    addr3 = 16'h0000; wr_en3 = 1'b1; rd_en3 = 1'b1; wr_data3 = '0; dev_ack3 = '0; dev_rd_data3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_en3 = 1'b0; rd_en3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if ({busy, done, err, cs, dev_we, dev_re, dev_addr, dev_wr_data, rd_data} !== '0) begin
        n_err++;
        $display("FAIL reset c=%0d outputs: got busy=%b done=%b err=%b cs=%b we=%b re=%b da=%h wd=%h rd=%h want all 0",
                 c, busy, done, err, cs, dev_we, dev_re, dev_addr, dev_wr_data, rd_data);
      end
      n_cmp++;
      if ({busy3, done3, err3, cs3, dev_we3, dev_re3, dev_addr3, dev_wr_data3, rd_data3} !== '0) begin
        n_err++;
        $display("FAIL reset3 c=%0d outputs: got busy=%b done=%b cs=%b want all 0", c, busy3, done3, cs3);
      end
      @(posedge clk); @(negedge clk);
    end
    exp_rd = '0;
  endtask

  task automatic test_write_dev2();
    run_txn(16'h8123, 1'b1, 1'b0, 16'hBEEF, 2, 4'b0000, 1'b0);
  endtask

  task automatic test_read_dev1();
    run_txn(16'h4010, 1'b0, 1'b1, 16'h0000, 4, 4'b0001, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn(16'hC000 | 16'($urandom_range(0, 16'h3FFF)), 1'b0, 1'b1, 16'h0, 0, 4'b0000, 1'b0);
  endtask

  task automatic test_ack_on_timeout();
    run_txn(16'($urandom), 1'b0, 1'b1, 16'h0, TIMEOUT, 4'b0000, 1'b0);
    run_txn(16'($urandom), 1'b1, 1'b0, 16'($urandom), TIMEOUT, 4'b0000, 1'b0);
  endtask

  task automatic test_both_strobes();
    run_txn(16'h0ABC, 1'b1, 1'b1, 16'h1357, 1, 4'b0000, 1'b0);
  endtask

  task automatic test_busy_strobe();
    run_txn(16'h7FFF, 1'b0, 1'b1, 16'h0, 5, 4'b0000, 1'b1);
    run_txn(16'hC001, 1'b1, 1'b0, 16'h2468, 3, 4'b0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_txn(16'($urandom), 1'(i % 2), 1'b1, 16'($urandom), 1, 4'b0000, 1'b0);
  endtask

  task automatic test_unmapped();
    logic        exp_mapped;
    logic [15:0] a;
    a = 16'hC000;
    exp_mapped = (a[15:14] < 2'd3);
    addr3 = a; rd_en3 = 1'b1; wr_en3 = 1'b0;
    @(posedge clk); @(negedge clk);
    rd_en3 = 1'b0;
    n_cmp++;
    if ({busy3, done3, err3, cs3, rd_data3} !== {1'b1, 1'b1, ~exp_mapped, 3'b000, 16'hFFFF}) begin
      n_err++;
      $display("FAIL unmapped resp: got busy=%b done=%b err=%b cs=%b rd=%h want 1 1 1 000 ffff",
               busy3, done3, err3, cs3, rd_data3);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({busy3, done3, err3, cs3, rd_data3} !== {1'b0, 1'b0, 1'b0, 3'b000, 16'hFFFF}) begin
      n_err++;
      $display("FAIL unmapped idle: got busy=%b done=%b err=%b cs=%b rd=%h want 0 0 0 000 ffff",
               busy3, done3, err3, cs3, rd_data3);
    end
  endtask

  task automatic test_reset_mid_access();
    addr = 16'h4444; rd_en = 1'b1; wr_en = 1'b0; dev_ack = '0;
    @(posedge clk); @(negedge clk);
    rd_en = 1'b0;
    n_cmp++;
    if (cs !== 4'b0010) begin
      n_err++;
      $display("FAIL rst_mid access cs: got %b want 0010", cs);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    dev_ack = 4'b1111;
    exp_rd = '0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({busy, done, err, cs, dev_re, rd_data} !== '0) begin
        n_err++;
        $display("FAIL rst_mid c=%0d: got busy=%b done=%b err=%b cs=%b re=%b rd=%h want all 0",
                 c, busy, done, err, cs, dev_re, rd_data);
      end
      @(posedge clk); @(negedge clk);
    end
    dev_ack = '0;
  endtask

  task automatic test_random();
    int          d;
    logic        w;
    for (int i = 0; i < 25; i++) begin
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT + 3) : $urandom_range(1, 4);
      w = 1'($urandom);
      run_txn(16'($urandom), w, w ? 1'($urandom) : 1'b1, 16'($urandom), d, 4'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write_dev2();
    test_read_dev1();
    test_timeout();
    test_unmapped();
    test_both_strobes();
    test_busy_strobe();
    test_ack_on_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
